pipe_elastic_reg: RTL

Parametrised elastic pipeline register that replaces the fixed per-stage enable scheme between pipeline stages (fetch→decode→execute→memory→writeback) with a valid/ready handshake, a DEPTH-entry in-order buffer and a synchronous flush. Each inter-stage boundary instantiates one copy, with WIDTH set to the packed width of that stage's data struct. The block also keeps a saturating stall-cycle counter for performance debug.

---
 rtl/pipe_elastic_reg.sv | 79 +++++++
 1 files changed

// File: rtl/pipe_elastic_reg.sv
// Elastic valid/ready pipeline register with a DEPTH-entry
// in-order buffer, synchronous flush and a stall counter.
module pipe_elastic_reg #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  parameter int CNT_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [CNT_W-1:0]           stall_cycles
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH-1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    occ;
  logic             push;
  logic             pop;

  assign in_ready  = (occ != CNT_FULL);
  assign out_valid = (occ != '0);
  assign out_data  = mem[rd_ptr];
  assign count     = occ;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Pointer and occupancy bookkeeping; flush wins over handshakes.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        occ <= occ + 1'b1;
      end else if (pop && !push) begin
        occ <= occ - 1'b1;
      end
    end
  end

  // Payload storage; contents survive flush and reset.
  always_ff @(posedge clk) begin
    if (!reset && !flush && push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Saturating count of cycles where the head waits on downstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (!flush && out_valid && !out_ready) begin
      if (stall_cycles != '1) begin
        stall_cycles <= stall_cycles + 1'b1;
      end
    end
  end

endmodule
